// File: rtl/color_cmd_sequencer.sv
// rtl/color_cmd_sequencer.sv - queued symbol/hold command sequencer feeding the Color FSM input
// Optional issue counter enabled by defining COLOR_CMD_SEQUENCER_STATS_EN.
module color_cmd_sequencer #(
    parameter int          DEPTH     = 4,
    parameter int          HOLD_W    = 4,
    parameter logic [1:0]  IDLE_CODE = 2'h2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_data,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              cmd_ready,
    input  logic              flush,
    output logic [1:0]        out,
`ifdef COLOR_CMD_SEQUENCER_STATS_EN
    output logic [15:0]       issued_count,
`endif
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + HOLD_W;
    localparam logic [AW:0]       PTR_ONE  = 1;
    localparam logic [AW:0]       FULL_XOR = {1'b1, {AW{1'b0}}};
    localparam logic [HOLD_W-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    state_t            state_q;
    logic [1:0]        out_q;
    logic [HOLD_W-1:0] cnt_q, cur_hold_q;

    logic              empty, full, push, pop;
    logic [1:0]        head_data;
    logic [HOLD_W-1:0] head_hold;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
    assign cmd_ready = rst && !full;
    assign push      = cmd_valid && cmd_ready && !flush;
    assign {head_data, head_hold} = mem_q[rd_ptr_q[AW-1:0]];

    // Every path that leaves a symbol slot pops when a command is waiting.
    always_comb begin
        pop = 1'b0;
        if (rst && !flush && !empty) begin
            case (state_q)
                S_IDLE:  pop = 1'b1;
                S_ISSUE: pop = (cur_hold_q == '0);
                S_HOLD:  pop = (cnt_q == CNT_ONE);
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_data, cmd_hold};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state_q    <= S_IDLE;
            out_q      <= IDLE_CODE;
            cnt_q      <= '0;
            cur_hold_q <= '0;
        end else if (pop) begin
            state_q    <= S_ISSUE;
            out_q      <= head_data;
            cur_hold_q <= head_hold;
            cnt_q      <= '0;
        end else begin
            out_q <= IDLE_CODE;
            case (state_q)
                S_ISSUE: begin
                    if (cur_hold_q != '0) begin
                        cnt_q   <= cur_hold_q;
                        state_q <= S_HOLD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out  = out_q;
    assign busy = !empty || (state_q != S_IDLE);

`ifdef COLOR_CMD_SEQUENCER_STATS_EN
    logic [15:0] issued_q;

    // Counts every cycle spent in ISSUE, including one cut short by flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issued_q <= '0;
        end else if (state_q == S_ISSUE && issued_q != 16'hFFFF) begin
            issued_q <= issued_q + 16'd1;
        end
    end

    assign issued_count = issued_q;
`endif

endmodule

// File: tb/tb_color_cmd_sequencer.sv
// tb/tb_color_cmd_sequencer.sv - directed table-driven bench for color_cmd_sequencer
module tb_color_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_data;
    logic [3:0] cmd_hold;
    logic       cmd_ready;
    logic       flush;
    logic [1:0] out;
    logic       busy;
`ifdef COLOR_CMD_SEQUENCER_STATS_EN
    logic [15:0] issued_count;
`endif

    int checks   = 0;
    int failures = 0;

    color_cmd_sequencer #(.DEPTH(4), .HOLD_W(4), .IDLE_CODE(2'h2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_hold  (cmd_hold),
        .cmd_ready (cmd_ready),
        .flush     (flush),
        .out       (out),
`ifdef COLOR_CMD_SEQUENCER_STATS_EN
        .issued_count (issued_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] d;
        logic [3:0] h;
        logic       f;
        logic [1:0] eo;
        logic       eb;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [1:0] d, logic [3:0] h, logic f,
                                logic [1:0] eo, logic eb, logic er);
        vec_t r;
        r.v = v; r.d = d; r.h = h; r.f = f; r.eo = eo; r.eb = eb; r.er = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [3:0] h, input logic f);
        cmd_valid = v; cmd_data = d; cmd_hold = h; flush = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 2'h0, 4'h0, 1'b0);
        step();
        step();
        chk("reset_ready", {31'b0, cmd_ready}, 32'h0);
        chk("reset_out", {30'b0, out}, 32'h2);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        rst = 1'b1;
        #1;
        chk("release_ready", {31'b0, cmd_ready}, 32'h1);
    endtask

    // Queue {1,5} then two more commands, abort mid-HOLD via flush or reset.
    task automatic abort_test(input logic use_reset);
        int bad;
        drive(1'b1, 2'h1, 4'd5, 1'b0); step();
        drive(1'b0, 2'h0, 4'd0, 1'b0); step();
        chk("abort_issue_out", {30'b0, out}, 32'h1);
        drive(1'b1, 2'h0, 4'd0, 1'b0); step();
        drive(1'b1, 2'h1, 4'd0, 1'b0); step();
        chk("abort_in_hold_out", {30'b0, out}, 32'h2);
        if (use_reset) begin
            drive(1'b0, 2'h0, 4'd0, 1'b0);
            rst = 1'b0;
            step();
            chk("abort_rst_ready", {31'b0, cmd_ready}, 32'h0);
            step();
            chk("abort_rst_ready2", {31'b0, cmd_ready}, 32'h0);
            rst = 1'b1;
        end else begin
            drive(1'b0, 2'h0, 4'd0, 1'b1);
            step();
            flush = 1'b0;
        end
        chk("abort_out", {30'b0, out}, 32'h2);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        #1;
        chk("abort_ready", {31'b0, cmd_ready}, 32'h1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out !== 2'h2 || busy !== 1'b0) bad++;
        end
        chk("abort_no_emit", bad, 0);
    endtask

    initial begin
        logic [1:0] full_data [5];
        logic [1:0] exp_stream [22];

        do_reset();

        // Single, back-to-back, hold gap, 3h pass-through, flush-with-push.
        tbl.push_back(mk(1, 2'h1, 4'd0, 0, 2'h2, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h1, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 0, 1));
        tbl.push_back(mk(1, 2'h1, 4'd0, 0, 2'h2, 1, 1));
        tbl.push_back(mk(1, 2'h0, 4'd0, 0, 2'h1, 1, 1));
        tbl.push_back(mk(1, 2'h1, 4'd0, 0, 2'h0, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h1, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 0, 1));
        tbl.push_back(mk(1, 2'h1, 4'd3, 0, 2'h2, 1, 1));
        tbl.push_back(mk(1, 2'h1, 4'd0, 0, 2'h1, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h1, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 0, 1));
        tbl.push_back(mk(1, 2'h3, 4'd0, 0, 2'h2, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h3, 1, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 0, 1));
        tbl.push_back(mk(1, 2'h1, 4'd0, 1, 2'h2, 0, 1));
        tbl.push_back(mk(0, 2'h0, 4'd0, 0, 2'h2, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].f);
            step();
            chk($sformatf("vec%0d_out", i), {30'b0, out}, {30'b0, tbl[i].eo});
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
            chk($sformatf("vec%0d_ready", i), {31'b0, cmd_ready}, {31'b0, tbl[i].er});
        end
        drive(1'b0, 2'h0, 4'd0, 1'b0);

        // Full FIFO behind a maximum hold; 5th push must be refused.
        full_data[0] = 2'h0; full_data[1] = 2'h1; full_data[2] = 2'h3;
        full_data[3] = 2'h1; full_data[4] = 2'h0;
        for (int i = 0; i < 22; i++) exp_stream[i] = 2'h2;
        exp_stream[15] = 2'h0; exp_stream[16] = 2'h1;
        exp_stream[17] = 2'h3; exp_stream[18] = 2'h1;

        drive(1'b1, 2'h1, 4'd15, 1'b0); step();
        drive(1'b0, 2'h0, 4'd0, 1'b0); step();
        chk("full_issue_out", {30'b0, out}, 32'h1);
        for (int i = 0; i < 22; i++) begin
            if (i < 5) drive(1'b1, full_data[i], 4'd0, 1'b0);
            else       drive(1'b0, 2'h0, 4'd0, 1'b0);
            step();
            if (i == 3) chk("full_ready_after4", {31'b0, cmd_ready}, 32'h0);
            if (i == 4) chk("full_ready_after5", {31'b0, cmd_ready}, 32'h0);
            chk($sformatf("full_out%0d", i), {30'b0, out}, {30'b0, exp_stream[i]});
        end
        chk("full_busy_end", {31'b0, busy}, 32'h0);
        chk("full_ready_end", {31'b0, cmd_ready}, 32'h1);

        abort_test(1'b0);
        abort_test(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
